// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage running LOAD/STORE over a req/ack data-memory port
`ifndef EXEC
`define EXEC 1'b1
`endif
`ifndef LOAD
`define LOAD 5'b10000
`endif
`ifndef STORE
`define STORE 5'b10001
`endif
`ifndef NOP
`define NOP 16'h0000
`endif

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic        ex_valid,
  input  logic [15:0] ex_ir,
  input  logic [15:0] ex_reg_C,
  input  logic [15:0] ex_smdr,
  output logic        mem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] wb_ir,
  output logic [15:0] reg_C1,
  output logic        mem_err
);
  typedef enum logic {IDLE, WAIT} fsm_t;
  fsm_t        fsm;
  logic [15:0] ir_q;
  logic [7:0]  cnt;
  logic        is_load, is_store;
  assign is_load   = ex_ir[15:11] == `LOAD;
  assign is_store  = ex_ir[15:11] == `STORE;
  assign mem_ready = fsm == IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm        <= IDLE;
      cnt        <= '0;
      ir_q       <= `NOP;
      wb_ir      <= `NOP;
      reg_C1     <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      mem_err    <= 1'b0;
    end else if (state == `EXEC) begin
      if (fsm == IDLE) begin
        wb_ir <= `NOP;
        if (ex_valid && (is_load || is_store)) begin
          ir_q       <= ex_ir;
          dmem_req   <= 1'b1;
          dmem_we    <= is_store;
          dmem_addr  <= ex_reg_C;
          dmem_wdata <= is_store ? ex_smdr : 16'h0000;
          cnt        <= '0;
          fsm        <= WAIT;
        end else if (ex_valid) begin
          wb_ir  <= ex_ir;
          reg_C1 <= ex_reg_C;
        end
      end else if (dmem_ack) begin
        dmem_req <= 1'b0;
        wb_ir    <= ir_q;
        reg_C1   <= dmem_we ? dmem_addr : dmem_rdata;
        fsm      <= IDLE;
      end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
        dmem_req <= 1'b0;
        mem_err  <= 1'b1;
        wb_ir    <= `NOP;
        fsm      <= IDLE;
      end else begin
        cnt   <= cnt + 8'd1;
        wb_ir <= `NOP;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenario tests for mem_stage with hand-computed expectations.
module tb_mem_stage;
  localparam logic [15:0] ADD_R3   = 16'h0312;
  localparam logic [15:0] LOAD_R5  = 16'h8500;
  localparam logic [15:0] STORE_R2 = 16'h8A00;
  logic clock = 0, reset = 0, state = 1, ex_valid = 0, dmem_ack = 0;
  logic [15:0] ex_ir = 0, ex_reg_C = 0, ex_smdr = 0, dmem_rdata = 0;
  logic mem_ready, dmem_req, dmem_we, mem_err;
  logic [15:0] dmem_addr, dmem_wdata, wb_ir, reg_C1;
  int checks = 0, errors = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .state(state), .ex_valid(ex_valid), .ex_ir(ex_ir),
    .ex_reg_C(ex_reg_C), .ex_smdr(ex_smdr), .mem_ready(mem_ready), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_ir(wb_ir), .reg_C1(reg_C1), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [15:0] ir, input logic [15:0] c, input logic [15:0] d);
    ex_valid = 1; ex_ir = ir; ex_reg_C = c; ex_smdr = d;
    tick();
    ex_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); reset = 0;
    checks++; if (wb_ir !== 16'h0) begin errors++; $display("FAIL reset_wb_ir got %h exp 0000", wb_ir); end
    checks++; if (reg_C1 !== 16'h0) begin errors++; $display("FAIL reset_reg_C1 got %h exp 0000", reg_C1); end
    checks++; if ({dmem_req, dmem_we, mem_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {dmem_req, dmem_we, mem_err}); end
    checks++; if ({dmem_addr, dmem_wdata} !== 32'h0) begin errors++; $display("FAIL reset_addr_data got %h exp 0", {dmem_addr, dmem_wdata}); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", mem_ready); end
  endtask

  task automatic test_alu();
    issue(ADD_R3, 16'h1234, 16'h9999);
    checks++; if (wb_ir !== ADD_R3) begin errors++; $display("FAIL alu_wb_ir got %h exp %h", wb_ir, ADD_R3); end
    checks++; if (reg_C1 !== 16'h1234) begin errors++; $display("FAIL alu_reg_C1 got %h exp 1234", reg_C1); end
    checks++; if ({mem_ready, dmem_req} !== 2'b10) begin errors++; $display("FAIL alu_ready_req got %b exp 10", {mem_ready, dmem_req}); end
    tick();
    checks++; if (wb_ir !== 16'h0) begin errors++; $display("FAIL bubble_wb_ir got %h exp 0000", wb_ir); end
    checks++; if (reg_C1 !== 16'h1234) begin errors++; $display("FAIL bubble_reg_C1 got %h exp 1234", reg_C1); end
  endtask

  task automatic test_load();
    issue(LOAD_R5, 16'h0040, 16'h7777);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, 16'h0040}) begin errors++; $display("FAIL load_req%0d got %b%b %h exp 10 0040", i, dmem_req, dmem_we, dmem_addr); end
      checks++; if ({mem_ready, wb_ir} !== 17'h0) begin errors++; $display("FAIL load_wait%0d ready=%b wb_ir=%h exp 0 0000", i, mem_ready, wb_ir); end
      if (i == 2) begin dmem_ack = 1; dmem_rdata = 16'hBEEF; end
      tick();
    end
    dmem_ack = 0;
    checks++; if (wb_ir !== LOAD_R5) begin errors++; $display("FAIL load_wb_ir got %h exp %h", wb_ir, LOAD_R5); end
    checks++; if (reg_C1 !== 16'hBEEF) begin errors++; $display("FAIL load_reg_C1 got %h exp beef", reg_C1); end
    checks++; if ({mem_ready, dmem_req} !== 2'b10) begin errors++; $display("FAIL load_done got %b exp 10", {mem_ready, dmem_req}); end
  endtask

  task automatic test_store();
    issue(STORE_R2, 16'h0010, 16'h5A5A);
    dmem_ack = 1;
    checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {2'b11, 16'h0010, 16'h5A5A}) begin errors++; $display("FAIL store_req got %b%b %h %h exp 11 0010 5a5a", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    tick(); dmem_ack = 0;
    checks++; if (wb_ir !== STORE_R2) begin errors++; $display("FAIL store_wb_ir got %h exp %h", wb_ir, STORE_R2); end
    checks++; if (reg_C1 !== 16'h0010) begin errors++; $display("FAIL store_reg_C1 got %h exp 0010", reg_C1); end
    checks++; if ({dmem_req, mem_ready} !== 2'b01) begin errors++; $display("FAIL store_done got %b exp 01", {dmem_req, mem_ready}); end
  endtask

  task automatic test_timeout();
    issue(LOAD_R5, 16'h0020, 16'h0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL timeout_req%0d got %b exp 1", i, dmem_req); end
      tick();
    end
    checks++; if ({dmem_req, mem_err, mem_ready} !== 3'b011) begin errors++; $display("FAIL timeout_flags got %b exp 011", {dmem_req, mem_err, mem_ready}); end
    checks++; if (wb_ir !== 16'h0) begin errors++; $display("FAIL timeout_wb_ir got %h exp 0000", wb_ir); end
    issue(ADD_R3, 16'h7777, 16'h0);
    checks++; if ({wb_ir, reg_C1} !== {ADD_R3, 16'h7777}) begin errors++; $display("FAIL timeout_next got %h %h exp %h 7777", wb_ir, reg_C1, ADD_R3); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", mem_err); end
  endtask

  task automatic test_freeze();
    issue(LOAD_R5, 16'h0030, 16'h0);
    state = 0; dmem_ack = 1; dmem_rdata = 16'hCAFE;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({dmem_req, mem_ready, dmem_addr, wb_ir, reg_C1} !== {2'b10, 16'h0030, 16'h0, 16'h7777}) begin errors++; $display("FAIL freeze%0d got %b%b %h %h %h exp 10 0030 0000 7777", i, dmem_req, mem_ready, dmem_addr, wb_ir, reg_C1); end
    end
    state = 1; tick(); dmem_ack = 0;
    checks++; if ({wb_ir, reg_C1} !== {LOAD_R5, 16'hCAFE}) begin errors++; $display("FAIL freeze_done got %h %h exp %h cafe", wb_ir, reg_C1, LOAD_R5); end
    checks++; if ({dmem_req, mem_ready} !== 2'b01) begin errors++; $display("FAIL freeze_idle got %b exp 01", {dmem_req, mem_ready}); end
  endtask

  task automatic test_reset_mid_wait();
    issue(LOAD_R5, 16'h0044, 16'h0);
    tick();
    reset = 1; tick(); reset = 0;
    checks++; if ({dmem_req, mem_err, mem_ready} !== 3'b001) begin errors++; $display("FAIL rstwait_flags got %b exp 001", {dmem_req, mem_err, mem_ready}); end
    checks++; if ({wb_ir, reg_C1} !== 32'h0) begin errors++; $display("FAIL rstwait_out got %h %h exp 0000 0000", wb_ir, reg_C1); end
    dmem_ack = 1; dmem_rdata = 16'hDEAD; tick(); dmem_ack = 0;
    checks++; if ({wb_ir, reg_C1, dmem_req} !== 33'h0) begin errors++; $display("FAIL late_ack got %h %h %b exp 0000 0000 0", wb_ir, reg_C1, dmem_req); end
  endtask

  task automatic test_back_to_back();
    issue(LOAD_R5, 16'h0050, 16'h0);
    ex_valid = 1; ex_ir = STORE_R2; ex_reg_C = 16'h0060; ex_smdr = 16'h1111;
    dmem_ack = 1; dmem_rdata = 16'h2222;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", mem_ready); end
    tick(); dmem_ack = 0;
    checks++; if ({wb_ir, reg_C1, dmem_req, mem_ready} !== {LOAD_R5, 16'h2222, 2'b01}) begin errors++; $display("FAIL b2b_load got %h %h %b%b exp %h 2222 01", wb_ir, reg_C1, dmem_req, mem_ready, LOAD_R5); end
    tick(); ex_valid = 0;
    checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_ir} !== {2'b11, 16'h0060, 16'h1111, 16'h0}) begin errors++; $display("FAIL b2b_store_req got %b%b %h %h %h exp 11 0060 1111 0000", dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_ir); end
    dmem_ack = 1; tick(); dmem_ack = 0;
    checks++; if ({wb_ir, reg_C1} !== {STORE_R2, 16'h0060}) begin errors++; $display("FAIL b2b_store got %h %h exp %h 0060", wb_ir, reg_C1, STORE_R2); end
  endtask

  task automatic test_idle_ack();
    dmem_ack = 1; dmem_rdata = 16'h4321; tick(); dmem_ack = 0;
    checks++; if ({wb_ir, reg_C1, dmem_req} !== {16'h0, 16'h0060, 1'b0}) begin errors++; $display("FAIL idle_ack got %h %h %b exp 0000 0060 0", wb_ir, reg_C1, dmem_req); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_freeze();
    test_reset_mid_wait();
    test_back_to_back();
    test_idle_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
